// File: rtl/wallace_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/wallace_divider_if.sv
// Start/operand/result bundle between a requester and the divider.
interface wallace_divider_if
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic                   start;
   logic [2*WIDTH-1:0]     dividend;
   logic [WIDTH-1:0]       divisor;
   logic                   busy;
   logic                   done;
   logic [WIDTH-1:0]       quotient;
   logic [WIDTH-1:0]       remainder;
   logic                   div_zero;
   logic                   overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero, overflow
   );
endinterface

// File: rtl/wallace_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   r_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_out,
   output logic             q_bit
);
   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      shifted = {r_in, bit_in};
      q_bit   = (shifted >= {2'b00, divisor});
      // shifted < 2*divisor whenever q_bit is set, so the low WIDTH+1 bits hold the exact difference
      diff    = shifted[WIDTH:0] - {1'b0, divisor};
      r_out   = q_bit ? diff : shifted[WIDTH:0];
   end
endmodule

// File: rtl/wallace_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
module wallace_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   wallace_divider_if.slave   bus
);
   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dz_q, dz_d, ov_q, ov_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             fdz_q, fdz_d, fov_q, fov_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   step_r;
   logic             step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_in    (r_q),
      .bit_in  (q_q[WIDTH-1]),
      .divisor (dvs_q),
      .r_out   (step_r),
      .q_bit   (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      fdz_d   = fdz_q;
      fov_d   = fov_q;
      done_d  = (state_q == FINISH);

      // Visible results publish alongside done, and clear one edge after an accepted start,
      // so a back-to-back start in FINISH cannot wipe the results of the finishing operation.
      if (state_q == FINISH) begin
         quo_d = q_q;
         rem_d = r_q[WIDTH-1:0];
         fdz_d = dz_q;
         fov_d = ov_q;
      end else if (state_q == CALC && cnt_q == '0) begin
         quo_d = '0;
         rem_d = '0;
         fdz_d = 1'b0;
         fov_d = 1'b0;
      end

      case (state_q)
         IDLE, FINISH: begin
            if (bus.start) begin
               dvs_d = bus.divisor;
               cnt_d = '0;
               dz_d  = 1'b0;
               ov_d  = 1'b0;
               if (bus.divisor == '0) begin
                  dz_d    = 1'b1;
                  q_d     = '1;
                  r_d     = '0;
                  state_d = FINISH;
               end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                  ov_d    = 1'b1;
                  q_d     = '1;
                  r_d     = '0;
                  state_d = FINISH;
               end else begin
                  r_d     = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
                  q_d     = bus.dividend[WIDTH-1:0];
                  state_d = CALC;
               end
            end else if (state_q == FINISH) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            r_d   = step_r;
            q_d   = {q_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         fdz_q   <= 1'b0;
         fov_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         fdz_q   <= fdz_d;
         fov_q   <= fov_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = (state_q == CALC);
   assign bus.done      = done_q;
   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = fdz_q;
   assign bus.overflow  = fov_q;
endmodule

// File: tb/tb_wallace_divider.sv
// Directed bench for wallace_divider: latency, results, flags, back-to-back and async reset.
module tb_wallace_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   wallace_divider_if #(.WIDTH(32)) bus ();
   wallace_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Drives one start from IDLE and returns cycles until done (-1 on timeout).
   task automatic run_div(input logic [63:0] dvd, input logic [31:0] dvs, output int lat);
      bus.dividend = dvd;
      bus.divisor  = dvs;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({bus.busy, bus.done, bus.div_zero, bus.overflow} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.div_zero, bus.overflow});
      end
      n_tests++;
      if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_results got q=%h r=%h want 0/0", bus.quotient, bus.remainder);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_after_reset got=%b want=00", {bus.busy, bus.done});
      end
   endtask

   task automatic test_normal(input logic [63:0] dvd, input logic [31:0] dvs,
                              input logic [31:0] eq, input logic [31:0] er, input string nm);
      int lat;
      run_div(dvd, dvs, lat);
      n_tests++;
      if (lat !== 33) begin
         n_fail++;
         $display("FAIL %s_latency got=%0d want=33", nm, lat);
      end
      n_tests++;
      if (bus.quotient !== eq || bus.remainder !== er) begin
         n_fail++;
         $display("FAIL %s_result got q=%h r=%h want q=%h r=%h", nm, bus.quotient, bus.remainder, eq, er);
      end
      n_tests++;
      if ({bus.div_zero, bus.overflow, bus.busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s_flags got=%b want=000", nm, {bus.div_zero, bus.overflow, bus.busy});
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0 || bus.quotient !== eq) begin
         n_fail++;
         $display("FAIL %s_pulse_hold got done=%b q=%h want done=0 q=%h", nm, bus.done, bus.quotient, eq);
      end
   endtask

   task automatic test_basic();
      test_normal(64'd150, 32'd15, 32'd10, 32'd0, "div150_15");
      test_normal(64'd466, 32'd15, 32'd31, 32'd1, "div466_15");
      test_normal(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "divmax");
   endtask

   task automatic test_special();
      int lat;
      run_div(64'h1234_5678_9ABC_DEF0, 32'd0, lat);
      n_tests++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL divzero_latency got=%0d want=1", lat);
      end
      n_tests++;
      if ({bus.div_zero, bus.overflow} !== 2'b10 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd0) begin
         n_fail++;
         $display("FAIL divzero_result got dz=%b ov=%b q=%h r=%h want dz=1 ov=0 q=ffffffff r=0",
                  bus.div_zero, bus.overflow, bus.quotient, bus.remainder);
      end
      @(posedge clk); #1;
      run_div(64'h5_0000_0000, 32'd5, lat);
      n_tests++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL overflow_latency got=%0d want=1", lat);
      end
      n_tests++;
      if ({bus.div_zero, bus.overflow} !== 2'b01 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd0) begin
         n_fail++;
         $display("FAIL overflow_result got dz=%b ov=%b q=%h r=%h want dz=0 ov=1 q=ffffffff r=0",
                  bus.div_zero, bus.overflow, bus.quotient, bus.remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int          done_cyc[$];
      logic [31:0] done_q[$];
      logic [31:0] done_r[$];
      int          exp_cyc[3] = '{33, 66, 99};
      logic [31:0] exp_q[3]   = '{32'd25, 32'd31, 32'd10};
      for (int i = 0; i < 130; i++) begin
         bus.start = (i < 80);
         if (i == 0)       begin bus.dividend = 64'd625; bus.divisor = 32'd25; end
         else if (i == 33) begin bus.dividend = 64'd465; bus.divisor = 32'd15; end
         else if (i == 66) begin bus.dividend = 64'd150; bus.divisor = 32'd15; end
         else begin
            bus.dividend = 64'(1000 + i * 7);
            bus.divisor  = 32'(3 + i % 5);
         end
         @(posedge clk); #1;
         if (bus.done) begin
            done_cyc.push_back(i);
            done_q.push_back(bus.quotient);
            done_r.push_back(bus.remainder);
         end
      end
      bus.start = 1'b0;
      n_tests++;
      if (done_cyc.size() !== 3) begin
         n_fail++;
         $display("FAIL b2b_done_count got=%0d want=3", done_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (done_cyc[k] !== exp_cyc[k] || done_q[k] !== exp_q[k] || done_r[k] !== 32'd0) begin
               n_fail++;
               $display("FAIL b2b_op%0d got cyc=%0d q=%0d r=%0d want cyc=%0d q=%0d r=0",
                        k, done_cyc[k], done_q[k], done_r[k], exp_cyc[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic saw_done;
      bus.dividend = 64'd150;
      bus.divisor  = 32'd15;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_calc_busy got=%b want=1", bus.busy);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({bus.busy, bus.done, bus.div_zero, bus.overflow} !== 4'b0000 ||
          bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_async got busy=%b done=%b q=%h r=%h want all 0",
                  bus.busy, bus.done, bus.quotient, bus.remainder);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         saw_done |= bus.done;
      end
      rst = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         saw_done |= bus.done;
      end
      n_tests++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_no_done got=%b want=0", saw_done);
      end
      run_div(64'd625, 32'd25, lat);
      n_tests++;
      if (lat !== 33 || bus.quotient !== 32'd25 || bus.remainder !== 32'd0) begin
         n_fail++;
         $display("FAIL after_rst_div got lat=%0d q=%0d r=%0d want lat=33 q=25 r=0",
                  lat, bus.quotient, bus.remainder);
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #2;
      test_reset();
      test_basic();
      test_special();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
